param_multicycle_cpu: RTL and testbench

- Parametrised multicycle CPU core, successor to the fixed 16-bit, 8-register processor top.
- Width, register count and data-memory interface are configurable; the top instantiates it alongside external sync ROM/RAM.
- Last register index is the PC.
- Adds unsigned compare, a HALT state, a zero/non-zero flag and a debug register read port.

---
 rtl/param_multicycle_cpu_pkg.sv | 33 +++
 rtl/param_multicycle_cpu_if.sv | 38 +++
 rtl/param_multicycle_cpu_regfile.sv | 61 ++++++
 rtl/param_multicycle_cpu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_param_multicycle_cpu.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/param_multicycle_cpu_pkg.sv
// Shared definitions for the parametrised multicycle CPU.
//   - opcode encodings (4-bit field at the top of every instruction word)
//   - FSM state encoding
//   - small decode helper used by the controller
package cpu_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_IR,
    S_EXEC,
    S_IMM,
    S_MEMRD,
    S_HALTED
  } state_t;

  // Instructions that need a fourth cycle (immediate fetch or memory read).
  function automatic logic needs_extra_cycle(input logic [3:0] op);
    return (op == OP_MVI) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/param_multicycle_cpu_if.sv
// Memory-side bus of the multicycle CPU.
//   imem_addr  : instruction address (sync ROM answers one cycle later)
//   imem_rdata : instruction / immediate word
//   dmem_addr  : data address
//   dmem_wdata : store data
//   dmem_we    : store strobe, one cycle per ST
//   dmem_rdata : load data, valid one cycle after dmem_addr
// master = CPU core, slave = memory subsystem.
interface param_multicycle_cpu_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_addr,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    input  imem_rdata,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    output imem_rdata,
    output dmem_rdata
  );

endinterface

// File: rtl/param_multicycle_cpu_regfile.sv
// Register file of the multicycle CPU. The last register is the PC.
//   clock, resetn      : clock, asynchronous active-low reset
//   ra_sel / ra_data   : combinational read port A
//   rb_sel / rb_data   : combinational read port B
//   dbg_sel / dbg_data : combinational debug read port
//   we, wa, wd         : write port
//   pc_inc             : increment the PC (the write port wins over it)
//   pc                 : current PC value
module cpu_regfile #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [$clog2(NREGS)-1:0] ra_sel,
  output logic [DATA_W-1:0]        ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_sel,
  output logic [DATA_W-1:0]        rb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc
);

  localparam int RW = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam bit                IS_PC   = (gi == NREGS - 1);
      localparam logic [DATA_W-1:0] RST_VAL = IS_PC ? DATA_W'(RESET_PC) : '0;

      logic [DATA_W-1:0] q;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          q <= RST_VAL;
        end else if (we && (wa == RW'(gi))) begin
          // A writeback to the PC is a jump and overrides the increment.
          q <= wd;
        end else if (IS_PC && pc_inc) begin
          q <= q + DATA_W'(1);
        end
      end

      assign regs[gi] = q;
    end
  endgenerate

  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  assign dbg_data = regs[dbg_sel];
  assign pc       = regs[NREGS-1];

endmodule

// File: rtl/param_multicycle_cpu.sv
// Parametrised multicycle CPU core.
//   clock    : single clock, rising edge
//   resetn   : asynchronous active-low reset
//   run      : level, enables instruction fetch
//   mem      : memory bus (param_multicycle_cpu_if.master)
//   done     : pulse in the last cycle of every instruction
//   halted   : level, core stopped by HALT until reset
//   dbg_sel  : debug register select
//   dbg_data : combinational R[dbg_sel]
// Optional feature: define MUL_EN to make opcode 8 an unsigned multiply
// (low DATA_W bits kept); without it opcode 8 is a NOP and no multiplier
// is built.
// All bus outputs and done are registered: they are computed one edge
// ahead (in LOAD_IR, or on the edge that enters FETCH) so that they are
// valid during the cycle the instruction needs them.
module param_multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     run,
  param_multicycle_cpu_if.master   mem,
  output logic                     done,
  output logic                     halted,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int             RW     = $clog2(NREGS);
  localparam logic [RW-1:0]  PC_IDX = RW'(NREGS - 1);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic              nz;
  logic [DATA_W-1:0] imem_addr_reg;
  logic [DATA_W-1:0] dmem_addr_reg;
  logic [DATA_W-1:0] dmem_wdata_reg;
  logic              dmem_we_reg;
  logic              done_reg;
  logic              halted_reg;

  // Fields of the latched instruction.
  logic [3:0]    op;
  logic [RW-1:0] rx;
  logic [RW-1:0] ry;
  assign op = ir[DATA_W-1 -: 4];
  assign rx = ir[DATA_W-5 -: RW];
  assign ry = ir[DATA_W-5-RW -: RW];

  // Fields of the word arriving from the ROM, decoded during LOAD_IR.
  logic [3:0]    new_op;
  logic [RW-1:0] new_rx;
  logic [RW-1:0] new_ry;
  assign new_op = mem.imem_rdata[DATA_W-1 -: 4];
  assign new_rx = mem.imem_rdata[DATA_W-5 -: RW];
  assign new_ry = mem.imem_rdata[DATA_W-5-RW -: RW];

  // Low IR bits carry no meaning; keep them from looking like dead logic.
  logic unused_ir;
  assign unused_ir = ^ir;

  // Register file
  logic [RW-1:0]     ra_sel, rb_sel;
  logic [DATA_W-1:0] ra_data, rb_data, pc;
  logic              rf_we, pc_inc;
  logic [RW-1:0]     rf_wa;
  logic [DATA_W-1:0] rf_wd;

  // In LOAD_IR the read ports look ahead at the incoming instruction so
  // that the store address/data can be registered for EXEC.
  assign ra_sel = (state == S_LOAD_IR) ? new_rx : rx;
  assign rb_sel = (state == S_LOAD_IR) ? new_ry : ry;

  cpu_regfile #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .RESET_PC (RESET_PC)
  ) u_regfile (
    .clock    (clock),
    .resetn   (resetn),
    .ra_sel   (ra_sel),
    .ra_data  (ra_data),
    .rb_sel   (rb_sel),
    .rb_data  (rb_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (rf_wa),
    .wd       (rf_wd),
    .pc_inc   (pc_inc),
    .pc       (pc)
  );

  // ALU: single-cycle operations executed in EXEC.
  logic [DATA_W-1:0] alu_res;
  logic              alu_wr;
  logic              alu_sets_nz;

  always_comb begin
    alu_res     = '0;
    alu_wr      = 1'b0;
    alu_sets_nz = 1'b0;
    case (op)
      OP_MV: begin
        alu_res = rb_data;
        alu_wr  = 1'b1;
      end
      OP_MVNZ: begin
        alu_res = rb_data;
        alu_wr  = nz;
      end
      OP_ADD: begin
        alu_res     = ra_data + rb_data;
        alu_wr      = 1'b1;
        alu_sets_nz = 1'b1;
      end
      OP_SUB: begin
        alu_res     = ra_data - rb_data;
        alu_wr      = 1'b1;
        alu_sets_nz = 1'b1;
      end
      OP_SLT: begin
        alu_res     = (ra_data < rb_data) ? DATA_W'(1) : '0;
        alu_wr      = 1'b1;
        alu_sets_nz = 1'b1;
      end
`ifdef MUL_EN
      OP_MUL: begin
        alu_res     = ra_data * rb_data;
        alu_wr      = 1'b1;
        alu_sets_nz = 1'b1;
      end
`endif
      default: begin
        alu_wr = 1'b0;
      end
    endcase
  end

  // Register writeback and PC increment.
  always_comb begin
    rf_we  = 1'b0;
    rf_wa  = rx;
    rf_wd  = alu_res;
    pc_inc = 1'b0;
    case (state)
      S_FETCH: pc_inc = 1'b1;
      S_EXEC: begin
        if (op == OP_MVI) begin
          pc_inc = 1'b1;
        end else if (alu_wr) begin
          rf_we = 1'b1;
        end
      end
      S_IMM: begin
        rf_we = 1'b1;
        rf_wd = mem.imem_rdata;
      end
      S_MEMRD: begin
        rf_we = 1'b1;
        rf_wd = mem.dmem_rdata;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Address of the next fetch when leaving a done cycle: a writeback to the
  // PC in that same cycle redirects it.
  logic [DATA_W-1:0] fetch_addr;
  assign fetch_addr = (rf_we && (rf_wa == PC_IDX)) ? rf_wd : pc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      ir             <= '0;
      nz             <= 1'b0;
      imem_addr_reg  <= '0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= '0;
      dmem_we_reg    <= 1'b0;
      done_reg       <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      dmem_we_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state         <= S_FETCH;
            imem_addr_reg <= pc;
          end
        end

        S_FETCH: begin
          state <= S_LOAD_IR;
        end

        S_LOAD_IR: begin
          ir       <= mem.imem_rdata;
          state    <= S_EXEC;
          done_reg <= !needs_extra_cycle(new_op);
          if (new_op == OP_MVI) begin
            // PC already points past the instruction word.
            imem_addr_reg <= pc;
          end
          if ((new_op == OP_LD) || (new_op == OP_ST)) begin
            dmem_addr_reg <= rb_data;
          end
          if (new_op == OP_ST) begin
            dmem_wdata_reg <= ra_data;
            dmem_we_reg    <= 1'b1;
          end
        end

        S_EXEC: begin
          if (op == OP_MVI) begin
            state    <= S_IMM;
            done_reg <= 1'b1;
          end else if (op == OP_LD) begin
            state    <= S_MEMRD;
            done_reg <= 1'b1;
          end else if (op == OP_HALT) begin
            state      <= S_HALTED;
            halted_reg <= 1'b1;
          end else begin
            if (alu_sets_nz) begin
              nz <= (alu_res != '0);
            end
            state <= run ? S_FETCH : S_IDLE;
            if (run) begin
              imem_addr_reg <= fetch_addr;
            end
          end
        end

        S_IMM, S_MEMRD: begin
          state <= run ? S_FETCH : S_IDLE;
          if (run) begin
            imem_addr_reg <= fetch_addr;
          end
        end

        S_HALTED: begin
          state <= S_HALTED;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.imem_addr  = imem_addr_reg;
  assign mem.dmem_addr  = dmem_addr_reg;
  assign mem.dmem_wdata = dmem_wdata_reg;
  assign mem.dmem_we    = dmem_we_reg;
  assign done           = done_reg;
  assign halted         = halted_reg;

endmodule

// File: tb/tb_param_multicycle_cpu.sv
// Directed bench for param_multicycle_cpu (DATA_W=16, NREGS=8, RESET_PC=0)
// with a sync ROM and sync RAM model.
module tb_param_multicycle_cpu;

  localparam int DW = 16;
  localparam int NR = 8;

  localparam logic [3:0] MV = 4'd0, MVI = 4'd1, ADD = 4'd2, SUB = 4'd3,
                         LD = 4'd4, ST = 4'd5, MVNZ = 4'd6, SLT = 4'd7,
                         MUL = 4'd8, HALT = 4'd15;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          run    = 1'b0;
  logic          done;
  logic          halted;
  logic [2:0]    dbg_sel = '0;
  logic [DW-1:0] dbg_data;

  int errors = 0;
  int checks = 0;

  int            we_cnt = 0;
  logic [DW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;

  logic [DW-1:0] rom [256];
  logic [DW-1:0] ram [256];

  param_multicycle_cpu_if #(.DATA_W(DW)) bus ();

  param_multicycle_cpu #(
    .DATA_W   (DW),
    .NREGS    (NR),
    .RESET_PC (0)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .run      (run),
    .mem      (bus),
    .done     (done),
    .halted   (halted),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clock = ~clock;

  // Sync ROM and RAM (read-before-write).
  always @(posedge clock) begin
    bus.imem_rdata <= rom[bus.imem_addr[7:0]];
    if (bus.dmem_we) ram[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
    bus.dmem_rdata <= ram[bus.dmem_addr[7:0]];
  end

  // Store monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.dmem_we === 1'b1) begin
      we_cnt++;
      st_addr = bus.dmem_addr;
      st_data = bus.dmem_wdata;
    end
  end

  function automatic logic [DW-1:0] enc(input logic [3:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry);
    return {op, rx, ry, 6'b0};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] idx, input logic [DW-1:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Entered in the FETCH cycle (1 time unit after the edge); counts cycles
  // up to and including the done cycle, then steps past the writeback edge.
  task automatic run_instr(input string tag, input int exp_cycles);
    int cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({tag, " cycles"}, DW'(cyc), DW'(exp_cycles));
    $display("instr %s: done after %0d cycles", tag, cyc);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int d;
    int we0;
    logic [DW-1:0] mul_exp;

    for (int i = 0; i < 256; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
    rom[0]  = enc(MVI, 3'd0, 3'd0);   rom[1]  = 16'd5;
    rom[2]  = enc(MVI, 3'd1, 3'd0);   rom[3]  = 16'd3;
    rom[4]  = enc(ADD, 3'd0, 3'd1);
    rom[5]  = enc(SUB, 3'd0, 3'd0);
    rom[6]  = enc(MVNZ, 3'd2, 3'd1);
    rom[7]  = enc(ADD, 3'd0, 3'd1);
    rom[8]  = enc(MVNZ, 3'd2, 3'd1);
    rom[9]  = enc(MVI, 3'd3, 3'd0);   rom[10] = 16'h0010;
    rom[11] = enc(ST, 3'd1, 3'd3);
    rom[12] = enc(LD, 3'd4, 3'd3);
    rom[13] = enc(SLT, 3'd5, 3'd1);
    rom[14] = enc(SLT, 3'd4, 3'd5);
    rom[15] = enc(MVI, 3'd0, 3'd0);   rom[16] = 16'hFFFF;
    rom[17] = enc(MVI, 3'd1, 3'd0);   rom[18] = 16'd2;
    rom[19] = enc(MUL, 3'd0, 3'd1);
    rom[20] = enc(SUB, 3'd5, 3'd1);
    rom[21] = enc(MVI, 3'd7, 3'd0);   rom[22] = 16'h0020;
    rom[32] = enc(HALT, 3'd0, 3'd0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst done", DW'(done), 16'd0);
    check("rst halted", DW'(halted), 16'd0);
    check("rst dmem_we", DW'(bus.dmem_we), 16'd0);
    check("rst imem_addr", bus.imem_addr, 16'd0);
    check("rst dmem_addr", bus.dmem_addr, 16'd0);
    check_reg("rst pc", 3'd7, 16'd0);
    check_reg("rst r0", 3'd0, 16'd0);

    @(negedge clock);
    resetn = 1'b1;
    run    = 1'b1;
    @(posedge clock);
    #1;
    check("first fetch addr", bus.imem_addr, 16'd0);

    run_instr("MVI R0,#5", 4);
    run_instr("MVI R1,#3", 4);
    run_instr("ADD R0,R1", 3);
    check_reg("add r0", 3'd0, 16'd8);
    run_instr("SUB R0,R0", 3);
    check_reg("sub r0", 3'd0, 16'd0);
    run_instr("MVNZ R2,R1 z", 3);
    check_reg("mvnz z r2", 3'd2, 16'd0);
    run_instr("ADD R0,R1", 3);
    check_reg("add2 r0", 3'd0, 16'd3);
    run_instr("MVNZ R2,R1 nz", 3);
    check_reg("mvnz nz r2", 3'd2, 16'd3);
    run_instr("MVI R3,#0x10", 4);
    we0 = we_cnt;
    run_instr("ST R1,[R3]", 3);
    check("st we count", DW'(we_cnt - we0), 16'd1);
    check("st addr", st_addr, 16'h0010);
    check("st wdata", st_data, 16'd3);
    check("ram[0x10]", ram[16], 16'd3);
    run_instr("LD R4,[R3]", 4);
    check_reg("ld r4", 3'd4, 16'd3);
    run_instr("SLT R5,R1", 3);
    check_reg("slt true", 3'd5, 16'd1);
    run_instr("SLT R4,R5", 3);
    check_reg("slt false", 3'd4, 16'd0);
    run_instr("MVI R0,#FFFF", 4);
    run_instr("MVI R1,#2", 4);
    run_instr("MUL R0,R1", 3);
`ifdef MUL_EN
    mul_exp = 16'hFFFE;
`else
    mul_exp = 16'hFFFF;
`endif
    check_reg("mul r0", 3'd0, mul_exp);
    run_instr("SUB R5,R1 wrap", 3);
    check_reg("sub wrap r5", 3'd5, 16'hFFFF);
    run_instr("MVI R7,#0x20", 4);
    check("jump imem_addr", bus.imem_addr, 16'h0020);
    check_reg("jump pc", 3'd7, 16'h0020);
    run_instr("HALT", 3);
    check("halted", DW'(halted), 16'd1);

    d = 0;
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      @(posedge clock);
      #1;
      if (done === 1'b1) d++;
    end
    check("halt no done", DW'(d), 16'd0);
    check("halt still", DW'(halted), 16'd1);
    check("halt imem frozen", bus.imem_addr, 16'h0020);
    check_reg("halt pc", 3'd7, 16'h0021);

    // Reset from HALTED, then LD with run dropped mid-instruction.
    @(negedge clock);
    resetn = 1'b0;
    run    = 1'b0;
    #1;
    check("rst2 halted", DW'(halted), 16'd0);
    check("rst2 dmem_addr", bus.dmem_addr, 16'd0);
    check_reg("rst2 pc", 3'd7, 16'd0);
    rom[0] = enc(LD, 3'd4, 3'd3);
    rom[1] = enc(ST, 3'd4, 3'd3);
    ram[0] = 16'hABCD;
    @(negedge clock);
    resetn = 1'b1;
    run    = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    run = 1'b0;
    @(posedge clock);
    #1;
    check("ld run-drop done", DW'(done), 16'd1);
    $display("instr LD R4,[R3] with run dropped: done=%0b", done);
    @(posedge clock);
    #1;
    check("idle done low", DW'(done), 16'd0);
    check_reg("ld r4 abcd", 3'd4, 16'hABCD);
    d = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) d++;
    end
    check("idle no done", DW'(d), 16'd0);
    check_reg("idle pc", 3'd7, 16'd1);
    check("idle imem_addr", bus.imem_addr, 16'd0);

    // ST interrupted by reset in its EXEC cycle.
    run = 1'b1;
    @(posedge clock);
    #1;
    check("st fetch addr", bus.imem_addr, 16'd1);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    check("st exec we", DW'(bus.dmem_we), 16'd1);
    check("st exec wdata", bus.dmem_wdata, 16'hABCD);
    #1;
    resetn = 1'b0;
    #1;
    check("mid-st rst we", DW'(bus.dmem_we), 16'd0);
    check("mid-st rst done", DW'(done), 16'd0);
    check_reg("mid-st rst pc", 3'd7, 16'd0);
    $display("instr ST R4,[R3] aborted by reset: dmem_we=%0b", bus.dmem_we);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
